// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_tx_arb_pkg                                                   |
// | Brief  : Shared types/constants for the UART TX round-robin arbiter.       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package uart_tx_arb_pkg;

    localparam int DATA_W          = 8;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_picker                                                         |
// | Brief  : Combinational round-robin select, first set bit from pointer up.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module rr_picker
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [IDX_W-1:0]   o_grant_id,
    output logic               o_hit
);

    logic [NUM_REQ-1:0] w_rot;
    int                 w_idx;

    // Rotate so bit 0 is the pointer position; descending scan lets the closest hit win.
    always_comb begin
        w_rot      = NUM_REQ'({i_req, i_req} >> i_rr_ptr);
        o_grant_id = '0;
        o_hit      = 1'b0;
        w_idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_idx = int'(i_rr_ptr) + k;
                if (w_idx >= NUM_REQ) begin
                    w_idx = w_idx - NUM_REQ;
                end
                o_grant_id = IDX_W'(w_idx);
                o_hit      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_tx_arbiter                                                   |
// | Brief  : Shares one UART transmitter among NUM_REQ byte producers.         |
// |          UART_TX_ARB_TIMEOUT_EN enables the busy-rise timeout.             |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_parity,
    output logic [NUM_REQ-1:0]         req_ack,
    input  logic                       tx_busy,
    output logic                       tx_valid,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_parity_en,
    output logic [idx_w(NUM_REQ)-1:0]  grant_id,
    output logic                       active,
    output logic                       frame_done,
    output logic                       timeout_err
);

    localparam int                 c_IDX_W = idx_w(NUM_REQ);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported NUM_REQ/TIMEOUT_CYC");
    end

    state_t               r_state;
    state_t               w_next_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_grant_id;
    logic [DATA_W-1:0]    r_tx_data;
    logic                 r_tx_parity_en;
    logic                 r_tx_valid;
    logic [NUM_REQ-1:0]   r_req_ack;
    logic                 r_frame_done;
    logic                 w_timeout;

    logic [c_IDX_W-1:0]   w_pick_id;
    logic                 w_pick_hit;
    logic [DATA_W-1:0]    w_pick_data;
    logic                 w_pick_par;
    logic [NUM_REQ-1:0]   w_pick_onehot;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_picker (
        .i_req      (req_valid),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant_id (w_pick_id),
        .o_hit      (w_pick_hit)
    );

    always_comb begin
        w_pick_data   = '0;
        w_pick_par    = 1'b0;
        w_pick_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_id == c_IDX_W'(i)) begin
                w_pick_data      = req_data[i*DATA_W +: DATA_W];
                w_pick_par       = req_parity[i];
                w_pick_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (w_pick_hit) w_next_state = ST_LAUNCH;
            ST_LAUNCH:    w_next_state = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_next_state = ST_WAIT_DONE;
                end else if (w_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT_DONE: if (!tx_busy) w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Launch strobes are registered at the capture edge so they land in the LAUNCH cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr       <= '0;
            r_grant_id     <= '0;
            r_tx_data      <= '0;
            r_tx_parity_en <= 1'b0;
            r_tx_valid     <= 1'b0;
            r_req_ack      <= '0;
            r_frame_done   <= 1'b0;
        end else begin
            r_tx_valid   <= 1'b0;
            r_req_ack    <= '0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_hit) begin
                        r_tx_data      <= w_pick_data;
                        r_tx_parity_en <= w_pick_par;
                        r_grant_id     <= w_pick_id;
                        r_tx_valid     <= 1'b1;
                        r_req_ack      <= w_pick_onehot;
                    end
                end
                ST_LAUNCH:    r_rr_ptr <= (r_grant_id == c_LAST) ? '0 : r_grant_id + 1'b1;
                ST_WAIT_DONE: if (!tx_busy) r_frame_done <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_CNT_W-1:0] r_to_cnt;
    logic               r_timeout_err;

    // Fires on the TIMEOUT_CYC-th WAIT_BUSY cycle without busy.
    assign w_timeout = (r_state == ST_WAIT_BUSY) && !tx_busy &&
                       (r_to_cnt == c_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state == ST_LAUNCH) begin
                r_to_cnt <= '0;
            end else if (r_state == ST_WAIT_BUSY) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign req_ack      = r_req_ack;
    assign tx_valid     = r_tx_valid;
    assign tx_data      = r_tx_data;
    assign tx_parity_en = r_tx_parity_en;
    assign grant_id     = r_grant_id;
    assign active       = (r_state != ST_IDLE);
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_tx_arbiter                                                |
// | Brief  : Scoreboard bench for uart_tx_arbiter with a busy-driving TX model.|
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_uart_tx_arbiter;
    import uart_tx_arb_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_parity;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      tx_busy = 1'b0;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_parity_en;
    logic [1:0]                grant_id;
    logic                      active;
    logic                      frame_done;
    logic                      timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_parity   (req_parity),
        .req_ack      (req_ack),
        .tx_busy      (tx_busy),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_parity_en (tx_parity_en),
        .grant_id     (grant_id),
        .active       (active),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises the edge after tx_valid and stays high busy_len cycles.
    int busy_len   = 11;
    bit busy_stuck = 1'b0;
    int busy_cnt   = 0;

    always @(posedge clk) begin
        if (!reset || busy_stuck) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else if (tx_valid) begin
            tx_busy  <= 1'b1;
            busy_cnt <= busy_len - 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0] gid;
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input logic [1:0] gid, input logic [7:0] data, input logic par);
        exp_q.push_back(exp_t'{gid, data, par});
    endtask

    // Monitor: pops one expectation per launch and checks frame stability at frame_done.
    bit         frame_open = 1'b0;
    logic [7:0] cur_data   = '0;
    logic       cur_par    = 1'b0;
    int         n_launch   = 0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            frame_open = 1'b0;
        end else begin
            if (tx_valid) begin
                n_launch++;
                check("launch_after_done", 32'(frame_open), 0);
                if (exp_q.size() == 0) begin
                    check("launch_expected", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("grant_id", 32'(grant_id), 32'(mon_e.gid));
                    check("tx_data", 32'(tx_data), 32'(mon_e.data));
                    check("tx_parity_en", 32'(tx_parity_en), 32'(mon_e.par));
                    check("req_ack", 32'(req_ack), 32'(4'b0001 << mon_e.gid));
                    check("active_at_launch", 32'(active), 1);
                    cur_data = mon_e.data;
                    cur_par  = mon_e.par;
                end
                frame_open = 1'b1;
            end else if (req_ack != '0) begin
                check("stray_ack", 32'(req_ack), 0);
            end
            if (frame_done) begin
                check("done_data", 32'(tx_data), 32'(cur_data));
                check("done_parity", 32'(tx_parity_en), 32'(cur_par));
                frame_open = 1'b0;
            end
            if (timeout_err) begin
                frame_open = 1'b0;
            end
        end
    end

    task automatic wait_frames(input int n, input bit hold, input int hold_launches, input int budget);
        int done     = 0;
        int launches = 0;
        int cyc      = 0;
        while (done < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (tx_valid) launches++;
            if (!hold) begin
                req_valid = req_valid & ~req_ack;
            end else if (tx_valid && launches == hold_launches) begin
                req_valid = '0;
            end
            if (frame_done) done++;
        end
        check("frame_budget", 32'(done), 32'(n));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    int base;
    int cyc;
    int l0;
    int e0;
    int nerr;
    int bad_active;
    int bad_err;

    initial begin
        reset      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_parity = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({tx_valid, tx_data, tx_parity_en, req_ack, grant_id,
                                    active, frame_done, timeout_err}), 0);

        // Single request, latency and one-shot launch.
        reset = 1'b1;
        @(negedge clk);
        req_data[7:0] = 8'hA5;
        req_parity    = 4'b0001;
        req_valid     = 4'b0001;
        push_exp(2'd0, 8'hA5, 1'b1);
        base = n_launch;
        @(negedge clk);
        check("t1_valid_e0p1", 32'(tx_valid), 1);
        check("t1_ack_e0p1", 32'(req_ack), 32'(4'b0001));
        req_valid = req_valid & ~req_ack;
        @(negedge clk);
        check("t1_valid_e0p2", 32'(tx_valid), 0);
        check("t1_ack_e0p2", 32'(req_ack), 0);
        wait_frames(1, 1'b0, 0, 100);
        check("t1_launch_count", 32'(n_launch - base), 1);

        // Simultaneous requests at reset exit, with a 1-cycle busy pulse.
        pulse_reset();
        req_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        req_parity = 4'b0100;
        req_valid  = 4'b0110;
        busy_len   = 1;
        push_exp(2'd1, 8'h22, 1'b0);
        push_exp(2'd2, 8'h33, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        wait_frames(2, 1'b0, 0, 200);

        // Fairness: all requesters held for six frames.
        pulse_reset();
        req_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        req_parity = 4'b1010;
        req_valid  = 4'b1111;
        busy_len   = 3;
        push_exp(2'd0, 8'h10, 1'b0);
        push_exp(2'd1, 8'h11, 1'b1);
        push_exp(2'd2, 8'h12, 1'b0);
        push_exp(2'd3, 8'h13, 1'b1);
        push_exp(2'd0, 8'h10, 1'b0);
        push_exp(2'd1, 8'h11, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        wait_frames(6, 1'b1, 6, 400);

        // Reset during WAIT_DONE, then lowest request wins.
        pulse_reset();
        busy_len   = 11;
        req_data   = {8'h63, 8'h5A, 8'h61, 8'h00};
        req_parity = 4'b0010;
        req_valid  = 4'b0100;
        push_exp(2'd2, 8'h5A, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        while (!(active && tx_busy) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            req_valid = req_valid & ~req_ack;
        end
        check("t4_reached_busy", 32'(active && tx_busy), 1);
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        req_valid = 4'b1010;
        @(negedge clk);
        check("t4_reset_outputs", 32'({tx_valid, tx_data, tx_parity_en, req_ack, grant_id,
                                       active, frame_done, timeout_err}), 0);
        push_exp(2'd1, 8'h61, 1'b1);
        push_exp(2'd3, 8'h63, 1'b0);
        reset = 1'b1;
        wait_frames(2, 1'b0, 0, 200);

        // Busy never rises.
        pulse_reset();
        busy_stuck = 1'b1;
        req_data   = {8'h00, 8'h00, 8'h71, 8'h70};
        req_parity = 4'b0000;
`ifdef UART_TX_ARB_TIMEOUT_EN
        req_valid = 4'b0011;
        push_exp(2'd0, 8'h70, 1'b0);
        push_exp(2'd1, 8'h71, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cyc  = 0;
        l0   = -1;
        e0   = -1;
        nerr = 0;
        while (nerr < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            req_valid = req_valid & ~req_ack;
            if (tx_valid && l0 < 0) l0 = cyc;
            if (timeout_err) begin
                nerr++;
                if (e0 < 0) begin
                    e0 = cyc;
                    check("to_back_idle", 32'(active), 0);
                end
            end
        end
        check("to_pulse_count", 32'(nerr), 2);
        check("to_delay", 32'(e0 - l0), 32'(TIMEOUT_CYC + 1));
`else
        req_valid = 4'b0001;
        push_exp(2'd0, 8'h70, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        while (!tx_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("nto_launched", 32'(tx_valid), 1);
        req_valid  = '0;
        bad_active = 0;
        bad_err    = 0;
        repeat (100) begin
            @(negedge clk);
            if (!active) bad_active++;
            if (timeout_err) bad_err++;
        end
        check("nto_active_held", 32'(bad_active), 0);
        check("nto_no_timeout_err", 32'(bad_err), 0);
`endif
        pulse_reset();
        busy_stuck = 1'b0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
